// File: rtl/alu_pkg.sv
// Shared definitions for the parametrised sequencing ALU.
// Optional feature macro: ALU_MUL_EN (adds op 7 = MUL to the core and the auto sequence).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    // Last op of the auto sequence when the multiplier is not built in.
    localparam alu_op_e OP_LAST_BASE = OP_SHR;

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU: result, carry/borrow/shift-out and signed overflow.
// Optional feature macro: ALU_MUL_EN (op 7 = unsigned multiply, low half as result).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             v
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
`endif

    // Select the result and flags for the current op; op 7 without the multiplier yields all zeros.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
`ifdef ALU_MUL_EN
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                r = sum[MSB:0];
                c = sum[WIDTH];
                v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                r = diff[MSB:0];
                c = diff[WIDTH];
                v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                r = {a[MSB-1:0], 1'b0};
                c = a[MSB];
            end
            OP_SHR: begin
                r = {1'b0, a[MSB:1]};
                c = a[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                r = prod[MSB:0];
                v = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_param.sv
// Auto/manual sequencing ALU with tick prescaler and registered result/flags for display logic.
// Optional feature macro: ALU_MUL_EN (auto sequence spans 0..7 and manual op 7 is accepted).
module alu_seq_param
    import alu_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int TICK_CYCLES = 100_000_000,
    localparam int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    input  logic [2:0]       op_sel_i,
    input  logic             step_i,
    input  logic             hold_i,
    output logic [WIDTH-1:0] result_o,
    output logic [2:0]       op_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             op_chg_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);
`ifdef ALU_MUL_EN
    localparam logic [2:0] LAST_OP = 3'(OP_MUL);
`else
    localparam logic [2:0] LAST_OP = 3'(OP_LAST_BASE);
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       op_prev_q, op_prev_d;
    logic             op_chg_q, op_chg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             mode_edge;
    logic             tick;
    logic             op_sel_ok;
    logic [WIDTH-1:0] core_r;
    logic             core_c;
    logic             core_v;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (a_i),
        .b  (b_i),
        .op (alu_op_e'(op_q)),
        .r  (core_r),
        .c  (core_c),
        .v  (core_v)
    );

    // Prescaler: a mode change restarts the count and swallows any tick due that cycle.
    always_comb begin
        mode_d    = mode_i;
        mode_edge = mode_i ^ mode_q;
        tick      = (cnt_q == CNT_MAX) && !mode_edge;
        if (mode_edge || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Op sequencer: auto steps on unheld ticks, manual loads op_sel_i when it names a built-in op.
    always_comb begin
`ifdef ALU_MUL_EN
        op_sel_ok = 1'b1;
`else
        op_sel_ok = (op_sel_i != 3'(OP_MUL));
`endif
        op_d = op_q;
        if (mode_i) begin
            if (step_i && op_sel_ok) begin
                op_d = op_sel_i;
            end
        end else if (tick && !hold_i) begin
            op_d = (op_q == LAST_OP) ? 3'd0 : op_q + 3'd1;
        end
        op_prev_d = op_q;
        op_chg_d  = (op_q != op_prev_q);
    end

    // Output stage: capture the core result computed with the op in force before this edge.
    always_comb begin
        result_d = core_r;
        carry_d  = core_c;
        ovf_d    = core_v;
        zero_d   = (core_r == '0);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            op_q      <= 3'd0;
            op_prev_q <= 3'd0;
            op_chg_q  <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            op_q      <= op_d;
            op_prev_q <= op_prev_d;
            op_chg_q  <= op_chg_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result_o = result_q;
    assign op_o     = op_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;
    assign op_chg_o = op_chg_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed self-checking bench for alu_seq_param with WIDTH=8, TICK_CYCLES=4.
// Honours ALU_MUL_EN when the design is built with it.
module tb_alu_seq_param;

    localparam int WIDTH = 8;
    localparam int TICK  = 4;
`ifdef ALU_MUL_EN
    localparam int HAS_MUL = 1;
    localparam int LAST_OP = 7;
`else
    localparam int HAS_MUL = 0;
    localparam int LAST_OP = 6;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             mode_i = 1'b0;
    logic [2:0]       op_sel_i = 3'd0;
    logic             step_i = 1'b0;
    logic             hold_i = 1'b0;
    logic [WIDTH-1:0] result_o;
    logic [2:0]       op_o;
    logic             carry_o;
    logic             zero_o;
    logic             ovf_o;
    logic             op_chg_o;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] seqResult [0:7];

    alu_seq_param #(
        .WIDTH       (WIDTH),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_i      (a_i),
        .b_i      (b_i),
        .mode_i   (mode_i),
        .op_sel_i (op_sel_i),
        .step_i   (step_i),
        .hold_i   (hold_i),
        .result_o (result_o),
        .op_o     (op_o),
        .carry_o  (carry_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o),
        .op_chg_o (op_chg_o)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic mode,
                                 input logic [2:0] opSel, input logic step, input logic hold);
        a_i      = a;
        b_i      = b;
        mode_i   = mode;
        op_sel_i = opSel;
        step_i   = step;
        hold_i   = hold;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({carry_o, zero_o, ovf_o});
    endfunction

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        int expOp;
        int prevOp;
        seqResult = '{8'h10, 8'h0E, 8'h01, 8'h0F, 8'h0E, 8'h1E, 8'h07, 8'h0F};

        // Reset state.
        applyStimulus(8'h0F, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_result", 32'(result_o), 'h0);
        checkOutput("reset_op", 32'(op_o), 'h0);
        checkOutput("reset_flags", flags(), 'h0);
        checkOutput("reset_chg", 32'(op_chg_o), 'h0);

        // Auto sequence through every op and back to ADD.
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("auto_add_result", 32'(result_o), 'h10);
        checkOutput("auto_add_op", 32'(op_o), 'h0);
        for (int k = 1; k <= LAST_OP + 1; k++) begin
            expOp  = k % (LAST_OP + 1);
            prevOp = k - 1;
            repeat (2) @(negedge clk);
            checkOutput("pre_tick_op", 32'(op_o), 32'(prevOp));
            @(negedge clk);
            checkOutput("tick_op", 32'(op_o), 32'(expOp));
            checkOutput("tick_chg_low", 32'(op_chg_o), 'h0);
            @(negedge clk);
            checkOutput("seq_result", 32'(result_o), 32'(seqResult[expOp]));
            checkOutput("seq_chg_pulse", 32'(op_chg_o), 'h1);
        end

        // Hold across two ticks, then release.
        applyStimulus(8'h0F, 8'h01, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("hold_op", 32'(op_o), 'h0);
            checkOutput("hold_chg", 32'(op_chg_o), 'h0);
        end
        applyStimulus(8'h0F, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("release_wait_op", 32'(op_o), 'h0);
        @(negedge clk);
        checkOutput("release_tick_op", 32'(op_o), 'h1);
        @(negedge clk);
        checkOutput("release_result", 32'(result_o), 'h0E);

        // Manual mode flag vectors.
        applyStimulus(8'h7F, 8'h01, 1'b1, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("man_load_add", 32'(op_o), 'h0);
        @(negedge clk);
        checkOutput("add_ovf_result", 32'(result_o), 'h80);
        checkOutput("add_ovf_flags", flags(), 'b001);
        applyStimulus(8'hFF, 8'h01, 1'b1, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("add_carry_result", 32'(result_o), 'h00);
        checkOutput("add_carry_flags", flags(), 'b110);
        applyStimulus(8'h00, 8'h01, 1'b1, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("man_load_sub", 32'(op_o), 'h1);
        @(negedge clk);
        checkOutput("sub_borrow_result", 32'(result_o), 'hFF);
        checkOutput("sub_borrow_flags", flags(), 'b100);

        // Manual shift-left, then an attempted op 7.
        applyStimulus(8'h81, 8'h01, 1'b1, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("man_load_shl", 32'(op_o), 'h5);
        @(negedge clk);
        checkOutput("shl_result", 32'(result_o), 'h02);
        checkOutput("shl_flags", flags(), 'b100);
        checkOutput("shl_chg_pulse", 32'(op_chg_o), 'h1);
        applyStimulus(8'h81, 8'h01, 1'b1, 3'd7, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("op7_op", 32'(op_o), HAS_MUL ? 'h7 : 'h5);
        @(negedge clk);
        checkOutput("op7_op_again", 32'(op_o), HAS_MUL ? 'h7 : 'h5);
        checkOutput("op7_chg", 32'(op_chg_o), HAS_MUL ? 'h1 : 'h0);
        checkOutput("op7_result", 32'(result_o), HAS_MUL ? 'h81 : 'h02);

        // Back to auto: the toggle restarts the prescaler.
        applyStimulus(8'h0F, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("toggle_wait_op", 32'(op_o), HAS_MUL ? 'h7 : 'h5);
        @(negedge clk);
        checkOutput("toggle_tick_op", 32'(op_o), HAS_MUL ? 'h0 : 'h6);

        // Park on OR, go to auto, and hit reset two counts into the tick.
        applyStimulus(8'h0F, 8'h01, 1'b1, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(8'h0F, 8'h01, 1'b1, 3'd3, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(8'h0F, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_op", 32'(op_o), 'h3);
        checkOutput("pre_reset_result", 32'(result_o), 'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_result", 32'(result_o), 'h0);
        checkOutput("async_reset_op", 32'(op_o), 'h0);
        checkOutput("async_reset_flags", flags(), 'h0);
        checkOutput("async_reset_chg", 32'(op_chg_o), 'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_wait_op", 32'(op_o), 'h0);
        @(negedge clk);
        checkOutput("post_reset_tick_op", 32'(op_o), 'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised successor of the team's auto-cycling 8-bit demo ALU.
- Generic WIDTH datapath with a configurable tick prescaler and auto/manual operation sequencing.
- Registered result plus status flags (carry, zero, overflow), so the output is stable for the board-level 7-seg/LED display logic.
- Sits between the TinyTapeout top-level pin wrapper and the A/B input pins; the top level maps the low 8 bits to uo_out.

Parameters:
- WIDTH, 8, operand/result width (>=4).
- TICK_CYCLES, 100_000_000, clk cycles per auto-sequence step (>=2; simulation uses 4).
- CNT_W, $clog2(TICK_CYCLES), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- mode_i  in  1  0 = auto sequence on tick, 1 = manual select.
- op_sel_i  in  3  op code loaded in manual mode.
- step_i  in  1  manual load strobe, level-sampled each clk.
- hold_i  in  1  freeze the auto sequence (the prescaler keeps running).
- result_o  out  WIDTH  registered ALU result.
- op_o  out  3  op currently applied.
- carry_o  out  1  registered carry/borrow/shift-out.
- zero_o  out  1  registered result==0.
- ovf_o  out  1  registered signed overflow.
- op_chg_o  out  1  one-cycle pulse, the cycle after op_o changes.

Behaviour:
- Reset values: all outputs 0. Internal prescaler = 0, op = 0 (ADD). Reset is asynchronous and takes effect mid-tick or mid-operation with no residue.
- Op codes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR.
  - 5 SHL by 1 (LSB fill 0), 6 SHR logical by 1 (MSB fill 0).
  - 7: see Optional Feature.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps to 0.
  - tick = (cnt == TICK_CYCLES-1), a one-cycle strobe.
  - Any change of mode_i (edge detected against a registered copy) clears cnt to 0 that cycle, and no tick is generated.
- Op sequencer, auto (mode_i=0):
  - On tick with hold_i=0: op <= (op==LAST_OP) ? 0 : op+1.
  - LAST_OP = 7 if ALU_MUL_EN is defined, else 6.
  - On tick with hold_i=1: the tick is consumed and op is unchanged.
  - op_sel_i and step_i are ignored.
- Op sequencer, manual (mode_i=1):
  - step_i=1: op <= op_sel_i.
  - If op_sel_i==7 and ALU_MUL_EN is undefined: op is unchanged and no op_chg_o pulse.
  - tick and hold_i are ignored.
- op_chg_o: registered; pulses one cycle after any cycle in which op actually changed value. Loading the same value produces no pulse.
- Datapath latency: 1 cycle. result/flags at edge N+1 reflect a_i/b_i at edge N and the op value before that edge's update. On an op change, the new op's result appears one cycle after op_o changes.
- Arithmetic and flags:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum. ovf = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB: carry = borrow (a<b unsigned). ovf = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - SHL: carry = a[MSB]. SHR: carry = a[0]. ovf = 0.
  - AND/OR/XOR: carry = 0, ovf = 0.
  - zero_o = (result == 0) for every op.
- Undefined op (7 without ALU_MUL_EN, unreachable by design): result 0, flags 0 except zero_o=1.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 7 = MUL. result = low WIDTH bits of the unsigned a*b. ovf_o = upper WIDTH bits != 0. carry_o = 0. Auto sequence spans 0..7.
- Undefined: no multiplier is synthesised, auto sequence spans 0..6, and manual op 7 is rejected.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic[2:0] alu_op_e {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL}.
  - localparam OP_LAST_BASE = OP_SHR.
- Sub-module alu_core: purely combinational, parametrised WIDTH. Inputs a, b, op; outputs r, c, v. The multiplier sits in it under ALU_MUL_EN.
- alu_seq_param owns the prescaler, sequencer, mode-edge detect and output registers.

Test Plan (TICK_CYCLES=4):
- Reset/auto: release reset with a=8'h0F, b=8'h01, mode=0. result_o=8'h10 from cycle 1. op_o steps 0→1 after 4 cycles, then result_o=8'h0E and op_chg_o pulses once.
- Wrap: run 7 ticks without MUL → op_o sequence 0..6 then 0. With ALU_MUL_EN → 0..7 then 0.
- Flags: ADD a=8'h7F, b=8'h01 → result 8'h80, ovf=1, carry=0. ADD 8'hFF+8'h01 → 8'h00, carry=1, zero=1. SUB 8'h00-8'h01 → 8'hFF, carry=1.
- Hold: hold_i=1 across two ticks → op_o constant and no op_chg_o pulse. Release → advances on the next tick only.
- Manual: mode=1, op_sel=5, step=1, a=8'h81 → op_o=5, result 8'h02, carry=1. op_sel=7 without MUL → op_o stays 5. Toggle back to mode=0 → first tick comes 4 cycles after the toggle.
- Async reset mid-tick: assert rst_n=0 at cnt=2 with op=3 → all outputs 0 immediately. After release, the first tick comes 4 cycles later.
